// File: rtl/mu0_mux_pkg.sv
// Shared definitions for the MU0 N:1 stream multiplexer: mode encodings
// and the select-width helper used to size index ports.
package mu0_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Index width for n channels; never narrower than one bit.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// scanning upward from ptr, wrapping modulo N. N need not be a power of two.
module rr_arbiter
  import mu0_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            grant_valid,
  output logic [SELW-1:0] grant
);

  int startIdx;
  int scanIdx;

  // Scan N positions from the pointer and keep the first valid requester.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    scanIdx     = 0;
    startIdx    = (int'(ptr) < N) ? int'(ptr) : 0;
    for (int k = 0; k < N; k++) begin
      scanIdx = startIdx + k;
      if (scanIdx >= N) begin
        scanIdx = scanIdx - N;
      end
      if (!grant_valid && req[scanIdx]) begin
        grant_valid = 1'b1;
        grant       = SELW'(scanIdx);
      end
    end
  end

endmodule

// File: rtl/mux_nto1_stream.sv
// N-input registered stream multiplexer. Picks one valid/ready input per
// cycle (explicit select or round-robin) and holds it, tagged with its
// source index, in a one-entry output register with full throughput.
module mux_nto1_stream
  import mu0_mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  localparam int SELW = sel_width(N)
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] outData_q, outData_d;
  logic [SELW-1:0]  outSrc_q, outSrc_d;
  logic             outValid_q, outValid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             selValid;
  logic             arbValid;
  logic [SELW-1:0]  arbGrant;
  logic             grantValid;
  logic [SELW-1:0]  grantIdx;
  logic             canAccept;
  logic             transfer;
  logic [WIDTH-1:0] grantData;

  rr_arbiter #(.N(N)) uArbiter (
    .req         (in_valid),
    .ptr         (ptr_q),
    .grant_valid (arbValid),
    .grant       (arbGrant)
  );

  // Explicit-select grant; an index at or beyond N matches no channel.
  always_comb begin
    selValid = 1'b0;
    for (int g = 0; g < N; g++) begin
      if (sel == SELW'(g) && in_valid[g]) begin
        selValid = 1'b1;
      end
    end
  end

  // Choose between the select path and the arbiter, then form ready/transfer.
  always_comb begin
    grantValid = (mode == MODE_RR) ? arbValid : selValid;
    grantIdx   = (mode == MODE_RR) ? arbGrant : sel;
    canAccept  = !outValid_q || out_ready;
    transfer   = grantValid && canAccept;
    in_ready   = '0;
    grantData  = '0;
    for (int g = 0; g < N; g++) begin
      if (grantIdx == SELW'(g)) begin
        in_ready[g] = transfer;
        grantData   = in_data[g*WIDTH +: WIDTH];
      end
    end
  end

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    outData_d  = outData_q;
    outSrc_d   = outSrc_q;
    outValid_d = outValid_q;
    ptr_d      = ptr_q;
    if (transfer) begin
      outData_d  = grantData;
      outSrc_d   = grantIdx;
      outValid_d = 1'b1;
      if (mode == MODE_RR) begin
        ptr_d = (grantIdx == SELW'(N - 1)) ? '0 : grantIdx + 1'b1;
      end
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // State registers; reset drops any held word and rewinds the pointer.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      outData_q  <= '0;
      outSrc_q   <= '0;
      outValid_q <= 1'b0;
      ptr_q      <= '0;
    end else begin
      outData_q  <= outData_d;
      outSrc_q   <= outSrc_d;
      outValid_q <= outValid_d;
      ptr_q      <= ptr_d;
    end
  end

  assign out_data  = outData_q;
  assign out_src   = outSrc_q;
  assign out_valid = outValid_q;

endmodule
